padframe_cfg_ctrl: RTL

Core-side configuration controller for the 46 bidirectional GPIO pads of the half padframe. It holds a shadow configuration word per pad, written and read over a valid/ready register port. On a commit command it copies shadow to active one pad at a time, with a programmable stagger to limit simultaneous-switching noise on DVDD/DVSS. The active registers drive the pad control inputs (CS, SL, IE, OE, PU, PD, PDRV0/1, A) directly. Pad outputs Y are synchronised to `clk` for readback.

---
 rtl/padframe_cfg_pkg.sv | 31 +++
 rtl/padframe_cfg_ctrl_sync2.sv | 30 +++
 rtl/padframe_cfg_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/padframe_cfg_pkg.sv
// ----------------------------------------------------------------------------
// padframe_cfg_pkg : shared field map, reset word and FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package padframe_cfg_pkg;

  localparam int CFG_W = 9;

  localparam int OE    = 0;
  localparam int IE    = 1;
  localparam int PU    = 2;
  localparam int PD    = 3;
  localparam int CS    = 4;
  localparam int SL    = 5;
  localparam int PDRV0 = 6;
  localparam int PDRV1 = 7;
  localparam int A     = 8;

  localparam logic [5:0]       ADDR_COMMIT = 6'd63;
  localparam logic [CFG_W-1:0] CFG_RESET   = 9'b0_0000_0010;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/padframe_cfg_ctrl_sync2.sv
// ----------------------------------------------------------------------------
// sync2 : generic two-flop synchroniser, one chain per bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/padframe_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// padframe_cfg_ctrl : shadow/active GPIO pad configuration with staggered commit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module padframe_cfg_ctrl
  import padframe_cfg_pkg::*;
#(
  parameter int NPADS   = 46,
  parameter int STAGGER = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_write,
  input  logic [5:0]        cfg_addr,
  input  logic [8:0]        cfg_wdata,
  output logic              cfg_rvalid,
  output logic [9:0]        cfg_rdata,
  input  logic [NPADS-1:0]  bidir_Y,
  output logic [NPADS-1:0]  bidir_OE,
  output logic [NPADS-1:0]  bidir_IE,
  output logic [NPADS-1:0]  bidir_PU,
  output logic [NPADS-1:0]  bidir_PD,
  output logic [NPADS-1:0]  bidir_CS,
  output logic [NPADS-1:0]  bidir_SL,
  output logic [NPADS-1:0]  bidir_PDRV0,
  output logic [NPADS-1:0]  bidir_PDRV1,
  output logic [NPADS-1:0]  bidir_A,
  output logic              busy,
  output logic              commit_done
);

  localparam logic [5:0] LAST_IDX = 6'(NPADS - 1);
  localparam logic [5:0] NPADS_A  = 6'(NPADS);
  localparam logic [3:0] T_RELOAD = 4'(STAGGER - 1);

  logic [CFG_W-1:0] shadow [NPADS];
  logic [CFG_W-1:0] active [NPADS];
  state_t           state;
  logic [5:0]       idx;
  logic [3:0]       timer;
  logic [NPADS-1:0] sync_y;
  logic             accept;
  logic             in_range;

  sync2 #(.WIDTH(NPADS)) u_sync_y (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bidir_Y),
    .q     (sync_y)
  );

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == COMMIT);
  assign accept    = cfg_valid && cfg_ready;
  assign in_range  = (cfg_addr < NPADS_A);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      cfg_rvalid  <= 1'b0;
      cfg_rdata   <= '0;
      commit_done <= 1'b0;
      for (int i = 0; i < NPADS; i++) begin
        shadow[i] <= CFG_RESET;
        active[i] <= CFG_RESET;
      end
    end else begin
      cfg_rvalid  <= 1'b0;
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cfg_write) begin
              if (in_range) begin
                shadow[cfg_addr] <= cfg_wdata;
              end else if (cfg_addr == ADDR_COMMIT && cfg_wdata[0]) begin
                state <= COMMIT;
                idx   <= '0;
                timer <= '0;
              end
            end else begin
              cfg_rvalid <= 1'b1;
              if (in_range)
                cfg_rdata <= {sync_y[cfg_addr], shadow[cfg_addr]};
              else if (cfg_addr == ADDR_COMMIT)
                cfg_rdata <= {9'b0, busy};
              else
                cfg_rdata <= '0;
            end
          end
        end
        COMMIT: begin
          // Shadow is frozen here since no request is accepted, so active ends up a clean snapshot.
          if (timer == '0) begin
            active[idx] <= shadow[idx];
            timer       <= T_RELOAD;
            idx         <= idx + 6'd1;
            if (idx == LAST_IDX) begin
              state       <= IDLE;
              commit_done <= 1'b1;
            end
          end else begin
            timer <= timer - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NPADS; i++) begin : g_pad
    assign bidir_OE[i]    = active[i][OE];
    assign bidir_IE[i]    = active[i][IE];
    assign bidir_PU[i]    = active[i][PU];
    assign bidir_PD[i]    = active[i][PD];
    assign bidir_CS[i]    = active[i][CS];
    assign bidir_SL[i]    = active[i][SL];
    assign bidir_PDRV0[i] = active[i][PDRV0];
    assign bidir_PDRV1[i] = active[i][PDRV1];
    assign bidir_A[i]     = active[i][A];
  end

endmodule

`default_nettype wire
